// File: rtl/cv32e40p_tb_subsys.sv
// cv32e40p_tb_subsys: simulation subsystem around one cv32e40p_core.
// Contains a unified two-port byte RAM (ram_i.dp_ram_i) and memory-mapped
// test peripherals: character out (0x1000_0000), status (0x2000_0000) and
// exit (0x2000_0004).
// Optional feature macro: CV32E40P_TB_STDOUT_EN
// (prints the character-port writes).
// A reduced-ISA cv32e40p_core stand-in is kept at the end of this file so the
// subsystem elaborates on its own. It supports LUI/ADDI/LW/SB/SW/JAL over the
// same OBI-style port names. Drop it when building against the real core.

module dp_ram #(
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk,
    input  logic                  en_a,
    input  logic [ADDR_WIDTH-3:0] addr_a,
    output logic [31:0]           rdata_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [3:0]            be_b,
    input  logic [ADDR_WIDTH-3:0] addr_b,
    input  logic [31:0]           wdata_b,
    output logic [31:0]           rdata_b
);
    localparam int WORD_COUNT = (2 ** ADDR_WIDTH) / 4;

    logic [7:0]  mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0] temp_mem [0:WORD_COUNT-1];

    // Byte-enabled write on the data port; plain always so the bench may preload mem
    always @(posedge clk) begin
        if (en_b && we_b) begin
            for (int i = 0; i < 4; i++) begin
                if (be_b[i]) mem[{addr_b, 2'(i)}] <= wdata_b[8*i +: 8];
            end
        end
    end

    // Registered little-endian word reads; a same-cycle write is not seen (old data)
    always_ff @(posedge clk) begin
        if (en_a) rdata_a <= {mem[{addr_a, 2'd3}], mem[{addr_a, 2'd2}],
                              mem[{addr_a, 2'd1}], mem[{addr_a, 2'd0}]};
        if (en_b) rdata_b <= {mem[{addr_b, 2'd3}], mem[{addr_b, 2'd2}],
                              mem[{addr_b, 2'd1}], mem[{addr_b, 2'd0}]};
    end
endmodule

module cv32e40p_tb_subsys #(
    parameter int          INSTR_RDATA_WIDTH = 32,
    parameter int          RAM_ADDR_WIDTH    = 22,
    parameter logic [31:0] BOOT_ADDR         = 'h80,
    parameter int          PULP_XPULP        = 0,
    parameter int          PULP_CLUSTER      = 0,
    parameter int          FPU               = 0,
    parameter int          PULP_ZFINX        = 0,
    parameter int          NUM_MHPMCOUNTERS  = 1,
    parameter logic [31:0] DM_HALTADDRESS    = 32'h1A11_0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
`ifdef CV32E40P_TB_STDOUT_EN
    localparam bit STDOUT_EN = 1'b1;
`else
    localparam bit STDOUT_EN = 1'b0;
`endif

    logic                         instr_req, instr_gnt, instr_rvalid;
    logic [31:0]                  instr_addr;
    logic [INSTR_RDATA_WIDTH-1:0] instr_rdata;
    logic                         data_req, data_gnt, data_rvalid, data_we;
    logic [3:0]                   data_be;
    logic [31:0]                  data_addr, data_wdata, data_rdata, ram_rdata_b;
    logic                         irq_ack, core_sleep;
    logic [4:0]                   irq_id;
    logic                         ram_sel, char_wr, status_wr, exit_wr, ram_sel_reg;

    assign instr_gnt = instr_req;
    assign data_gnt  = data_req;

    assign ram_sel   = (data_addr[31:RAM_ADDR_WIDTH] == '0);
    assign char_wr   = data_req && data_we && (data_addr == 32'h1000_0000);
    assign status_wr = data_req && data_we && (data_addr == 32'h2000_0000);
    assign exit_wr   = data_req && data_we && (data_addr == 32'h2000_0004);

    assign data_rdata = ram_sel_reg ? ram_rdata_b : 32'h0;

    logic unused_sig;
    assign unused_sig = ^{instr_addr[31:RAM_ADDR_WIDTH], instr_addr[1:0], irq_ack, irq_id, core_sleep};

    if (1) begin : ram_i
        dp_ram #(.ADDR_WIDTH(RAM_ADDR_WIDTH)) dp_ram_i (
            .clk     (clk),
            .en_a    (instr_req),
            .addr_a  (instr_addr[RAM_ADDR_WIDTH-1:2]),
            .rdata_a (instr_rdata),
            .en_b    (data_req && ram_sel),
            .we_b    (data_we),
            .be_b    (data_be),
            .addr_b  (data_addr[RAM_ADDR_WIDTH-1:2]),
            .wdata_b (data_wdata),
            .rdata_b (ram_rdata_b)
        );
    end

    cv32e40p_core #(
        .PULP_XPULP       (PULP_XPULP),
        .PULP_CLUSTER     (PULP_CLUSTER),
        .FPU              (FPU),
        .PULP_ZFINX       (PULP_ZFINX),
        .NUM_MHPMCOUNTERS (NUM_MHPMCOUNTERS)
    ) core_i (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .pulp_clock_en_i     (1'b1),
        .scan_cg_en_i        (1'b0),
        .boot_addr_i         (BOOT_ADDR),
        .mtvec_addr_i        (32'h0),
        .dm_halt_addr_i      (DM_HALTADDRESS),
        .hart_id_i           (32'h0),
        .dm_exception_addr_i (32'h0),
        .instr_req_o         (instr_req),
        .instr_gnt_i         (instr_gnt),
        .instr_rvalid_i      (instr_rvalid),
        .instr_addr_o        (instr_addr),
        .instr_rdata_i       (instr_rdata),
        .data_req_o          (data_req),
        .data_gnt_i          (data_gnt),
        .data_rvalid_i       (data_rvalid),
        .data_we_o           (data_we),
        .data_be_o           (data_be),
        .data_addr_o         (data_addr),
        .data_wdata_o        (data_wdata),
        .data_rdata_i        (data_rdata),
        .irq_i               (32'h0),
        .irq_ack_o           (irq_ack),
        .irq_id_o            (irq_id),
        .debug_req_i         (1'b0),
        .fetch_enable_i      (fetch_enable_i),
        .core_sleep_o        (core_sleep)
    );

    // Response valids one cycle after each grant, plus read-source select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_rvalid <= 1'b0;
            data_rvalid  <= 1'b0;
            ram_sel_reg  <= 1'b0;
        end else begin
            instr_rvalid <= instr_req;
            data_rvalid  <= data_req;
            ram_sel_reg  <= data_req && ram_sel;
        end
    end

    // Sticky test-status and exit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= 32'h0;
        end else begin
            if (status_wr && data_wdata == 32'd123456789) tests_passed_o <= 1'b1;
            if (status_wr && data_wdata == 32'd1)         tests_failed_o <= 1'b1;
            if (exit_wr) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= data_wdata;
            end
        end
    end

    // Simulation-only reporting: character output and dropped unmapped writes
    always @(posedge clk) begin
        if (rst_n && STDOUT_EN && char_wr) begin
            $write("%c", data_wdata[7:0]);
        end
        if (rst_n && data_req && data_we && !ram_sel && !char_wr && !status_wr && !exit_wr)
            $error("write to unmapped address %h dropped", data_addr);
    end
endmodule

module cv32e40p_core #(
    parameter int PULP_XPULP       = 0,
    parameter int PULP_CLUSTER     = 0,
    parameter int FPU              = 0,
    parameter int PULP_ZFINX       = 0,
    parameter int NUM_MHPMCOUNTERS = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pulp_clock_en_i,
    input  logic        scan_cg_en_i,
    input  logic [31:0] boot_addr_i,
    input  logic [31:0] mtvec_addr_i,
    input  logic [31:0] dm_halt_addr_i,
    input  logic [31:0] hart_id_i,
    input  logic [31:0] dm_exception_addr_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic [31:0] irq_i,
    output logic        irq_ack_o,
    output logic [4:0]  irq_id_o,
    input  logic        debug_req_i,
    input  logic        fetch_enable_i,
    output logic        core_sleep_o
);
    localparam logic [1:0] S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_MWAIT = 2'd3;

    logic [1:0]  state_reg;
    logic [31:0] pc_reg, addr_reg, wdata_reg;
    logic [3:0]  be_reg;
    logic        we_reg;
    logic [4:0]  rd_reg;
    logic [31:0] regs [0:31];
    logic [31:0] ir, rs1_val, rs2_val, imm_i, imm_s, imm_j, mem_addr;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    assign ir       = instr_rdata_i;
    assign rs1_val  = (ir[19:15] == 5'd0) ? 32'h0 : regs[ir[19:15]];
    assign rs2_val  = (ir[24:20] == 5'd0) ? 32'h0 : regs[ir[24:20]];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_j    = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    assign mem_addr = rs1_val + ((ir[6:0] == 7'b0100011) ? imm_s : imm_i);

    assign instr_req_o  = (state_reg == S_FETCH) && fetch_enable_i;
    assign instr_addr_o = pc_reg;
    assign data_req_o   = (state_reg == S_MEM);
    assign data_we_o    = we_reg;
    assign data_be_o    = be_reg;
    assign data_addr_o  = addr_reg;
    assign data_wdata_o = wdata_reg;
    assign irq_ack_o    = 1'b0;
    assign irq_id_o     = 5'd0;
    assign core_sleep_o = (state_reg == S_FETCH) && !fetch_enable_i;

    logic unused_in;
    assign unused_in = ^{pulp_clock_en_i, scan_cg_en_i, mtvec_addr_i, dm_halt_addr_i, hart_id_i,
                         dm_exception_addr_i, instr_gnt_i, data_gnt_i, irq_i, debug_req_i};

    // Register-file write selection for LUI/ADDI/JAL results and load data
    always_comb begin
        rf_we   = 1'b0;
        rf_addr = ir[11:7];
        rf_data = 32'h0;
        if (state_reg == S_EXEC && instr_rvalid_i) begin
            case (ir[6:0])
                7'b0110111: begin rf_we = 1'b1; rf_data = {ir[31:12], 12'h0}; end
                7'b0010011: begin rf_we = 1'b1; rf_data = rs1_val + imm_i; end
                7'b1101111: begin rf_we = 1'b1; rf_data = pc_reg + 32'd4; end
                default:    rf_we = 1'b0;
            endcase
        end else if (state_reg == S_MWAIT && data_rvalid_i && !we_reg) begin
            rf_we   = 1'b1;
            rf_addr = rd_reg;
            rf_data = data_rdata_i;
        end
    end

    // Register file (x0 reads as zero, so writes to it are harmless)
    always_ff @(posedge clk_i) begin
        if (rf_we) regs[rf_addr] <= rf_data;
    end

    // Fetch / execute / memory sequencing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= S_FETCH;
            pc_reg    <= boot_addr_i;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            be_reg    <= 4'h0;
            we_reg    <= 1'b0;
            rd_reg    <= 5'd0;
        end else begin
            case (state_reg)
                S_FETCH: if (fetch_enable_i) state_reg <= S_EXEC;
                S_EXEC: if (instr_rvalid_i) begin
                    state_reg <= S_FETCH;
                    pc_reg    <= pc_reg + 32'd4;
                    if (ir[6:0] == 7'b1101111) pc_reg <= pc_reg + imm_j;
                    if (ir[6:0] == 7'b0100011 || ir[6:0] == 7'b0000011) begin
                        state_reg <= S_MEM;
                        addr_reg  <= mem_addr;
                        rd_reg    <= ir[11:7];
                        we_reg    <= (ir[6:0] == 7'b0100011);
                        be_reg    <= (ir[6:0] == 7'b0100011 && ir[14:12] == 3'd0) ?
                                     (4'b0001 << mem_addr[1:0]) : 4'hF;
                        wdata_reg <= (ir[14:12] == 3'd0) ? {4{rs2_val[7:0]}} : rs2_val;
                    end
                end
                S_MEM:   state_reg <= S_MWAIT;
                default: if (data_rvalid_i) state_reg <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40p_tb_subsys.sv
// Testbench for cv32e40p_tb_subsys: preloads firmware through the RAM
// hierarchy, checks sticky status/exit outputs, data-port read data and
// response timing, asynchronous reset and rerun from the boot address.
module tb_cv32e40p_tb_subsys;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_enable_i = 1'b0;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] exit_value_o;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    cv32e40p_tb_subsys dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_enable_i (fetch_enable_i),
        .tests_passed_o (tests_passed_o),
        .tests_failed_o (tests_failed_o),
        .exit_valid_o   (exit_valid_o),
        .exit_value_o   (exit_value_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < 4; i++) dut.ram_i.dp_ram_i.mem[addr[21:0] + 22'(i)] = data[8*i +: 8];
    endtask

    task automatic load_prog(input logic [31:0] prog [], input int n);
        for (int i = 0; i < n; i++) load_word(32'h80 + 32'(4*i), prog[i]);
    endtask

    // Bus scoreboard: response timing, read data, and next-cycle status/exit updates
    logic        prev_req = 1'b0, prev_we = 1'b0;
    logic        pend_pass = 1'b0, pend_fail = 1'b0, pend_exit = 1'b0;
    logic [31:0] pend_val = 32'h0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0; pend_pass = 1'b0; pend_fail = 1'b0; pend_exit = 1'b0;
        end else begin
            check("data_rvalid_timing", {31'h0, dut.data_rvalid}, {31'h0, prev_req});
            if (prev_req && !prev_we) begin
                if (exp_q.size() == 0) check("read_unexpected", 32'h1, 32'h0);
                else check("read_data", dut.data_rdata, exp_q.pop_front());
            end
            if (pend_pass) check("passed_next_cycle", {31'h0, tests_passed_o}, 32'h1);
            if (pend_fail) check("failed_next_cycle", {31'h0, tests_failed_o}, 32'h1);
            if (pend_exit) begin
                check("exit_valid_next_cycle", {31'h0, exit_valid_o}, 32'h1);
                check("exit_value_next_cycle", exit_value_o, pend_val);
            end
            pend_pass = 1'b0; pend_fail = 1'b0; pend_exit = 1'b0;
            prev_req = dut.data_req;
            prev_we  = dut.data_we;
            if (dut.data_req) begin
                $display("txn addr=%h we=%b be=%h wdata=%h", dut.data_addr, dut.data_we, dut.data_be, dut.data_wdata);
                if (dut.data_we && dut.data_addr == 32'h2000_0000) begin
                    pend_pass = (dut.data_wdata == 32'd123456789);
                    pend_fail = (dut.data_wdata == 32'd1);
                end
                if (dut.data_we && dut.data_addr == 32'h2000_0004) begin
                    pend_exit = 1'b1;
                    pend_val  = dut.data_wdata;
                end
            end
        end
    end

    logic [31:0] prog_a [] = '{
        enc_u(7'b0110111, 5'd7, 20'h10000),
        enc_i(7'b0010011, 5'd8, 3'd0, 5'd0, 12'h048),
        enc_s(3'd2, 5'd7, 5'd8, 12'h000),
        enc_i(7'b0010011, 5'd8, 3'd0, 5'd0, 12'h069),
        enc_s(3'd2, 5'd7, 5'd8, 12'h000),
        enc_i(7'b0010011, 5'd8, 3'd0, 5'd0, 12'h00A),
        enc_s(3'd2, 5'd7, 5'd8, 12'h000),
        enc_u(7'b0110111, 5'd1, 20'h11223),
        enc_i(7'b0010011, 5'd1, 3'd0, 5'd1, 12'h344),
        enc_s(3'd2, 5'd0, 5'd1, 12'h100),
        enc_i(7'b0010011, 5'd2, 3'd0, 5'd0, 12'h0AA),
        enc_s(3'd0, 5'd0, 5'd2, 12'h101),
        enc_i(7'b0000011, 5'd3, 3'd2, 5'd0, 12'h100),
        enc_u(7'b0110111, 5'd6, 20'h20000),
        enc_i(7'b0000011, 5'd10, 3'd2, 5'd6, 12'h000),
        enc_u(7'b0110111, 5'd12, 20'h30000),
        enc_i(7'b0000011, 5'd11, 3'd2, 5'd12, 12'h000),
        enc_s(3'd2, 5'd6, 5'd0, 12'h004),
        enc_i(7'b0010011, 5'd8, 3'd0, 5'd0, 12'h005),
        enc_s(3'd2, 5'd6, 5'd8, 12'h004),
        enc_u(7'b0110111, 5'd9, 20'h075BD),
        enc_i(7'b0010011, 5'd9, 3'd0, 5'd9, 12'hD15),
        enc_s(3'd2, 5'd6, 5'd9, 12'h000),
        enc_s(3'd2, 5'd6, 5'd3, 12'h004),
        32'h0000_006F
    };

    logic [31:0] prog_b [] = '{
        enc_u(7'b0110111, 5'd6, 20'h20000),
        enc_i(7'b0010011, 5'd1, 3'd0, 5'd0, 12'h001),
        enc_s(3'd2, 5'd6, 5'd1, 12'h000),
        enc_i(7'b0010011, 5'd2, 3'd0, 5'd0, 12'h002),
        enc_s(3'd2, 5'd6, 5'd2, 12'h000),
        32'h0000_006F
    };

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_passed", {31'h0, tests_passed_o}, 32'h0);
        check("rst_failed", {31'h0, tests_failed_o}, 32'h0);
        check("rst_exit_valid", {31'h0, exit_valid_o}, 32'h0);
        check("rst_exit_value", exit_value_o, 32'h0);

        // Program A: char out, RAM byte merge, peripheral/unmapped reads, exits, pass
        rst_n = 1'b1;
        @(negedge clk);
        load_prog(prog_a, prog_a.size());
        exp_q = '{32'h1122_AA44, 32'h0, 32'h0};
        fetch_enable_i = 1'b1;

        for (int c = 0; c < 2000 && !exit_valid_o; c++) @(negedge clk);
        check("exit_valid_first", {31'h0, exit_valid_o}, 32'h1);
        check("exit_value_zero", exit_value_o, 32'h0);
        check("passed_before_pass_write", {31'h0, tests_passed_o}, 32'h0);

        for (int c = 0; c < 2000 && exit_value_o !== 32'd5; c++) @(negedge clk);
        check("exit_value_five", exit_value_o, 32'd5);

        for (int c = 0; c < 2000 && !tests_passed_o; c++) @(negedge clk);
        check("passed_set", {31'h0, tests_passed_o}, 32'h1);
        check("failed_stays_low", {31'h0, tests_failed_o}, 32'h0);

        for (int c = 0; c < 2000 && exit_value_o !== 32'h1122_AA44; c++) @(negedge clk);
        check("exit_value_load_result", exit_value_o, 32'h1122_AA44);
        repeat (10) @(negedge clk);
        check("exit_valid_sticky", {31'h0, exit_valid_o}, 32'h1);
        check("passed_sticky", {31'h0, tests_passed_o}, 32'h1);
        check("reads_all_seen", exp_q.size(), 32'h0);
        check("ram_byte_0x101", {24'h0, dut.ram_i.dp_ram_i.mem[22'h101]}, 32'h0000_00AA);

        // Asynchronous reset mid-cycle: outputs clear before the next edge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_passed", {31'h0, tests_passed_o}, 32'h0);
        check("async_rst_exit_valid", {31'h0, exit_valid_o}, 32'h0);
        check("async_rst_exit_value", exit_value_o, 32'h0);
        repeat (2) @(negedge clk);
        exp_q = '{32'h1122_AA44, 32'h0, 32'h0};
        rst_n = 1'b1;

        // Rerun from BOOT_ADDR with RAM preserved
        for (int c = 0; c < 2000 && exit_value_o !== 32'h1122_AA44; c++) @(negedge clk);
        check("rerun_exit_value", exit_value_o, 32'h1122_AA44);
        check("rerun_passed", {31'h0, tests_passed_o}, 32'h1);
        check("rerun_reads_all_seen", exp_q.size(), 32'h0);

        // Program B: fail code, then an ignored status value
        rst_n = 1'b0;
        fetch_enable_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_prog(prog_b, prog_b.size());
        exp_q.delete();
        fetch_enable_i = 1'b1;
        for (int c = 0; c < 2000 && !tests_failed_o; c++) @(negedge clk);
        check("failed_set", {31'h0, tests_failed_o}, 32'h1);
        repeat (30) @(negedge clk);
        check("failed_sticky", {31'h0, tests_failed_o}, 32'h1);
        check("passed_stays_low", {31'h0, tests_passed_o}, 32'h0);
        check("exit_valid_stays_low", {31'h0, exit_valid_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
